// File: rtl/onehot_mask_decoder.sv
// rtl/onehot_mask_decoder.sv - occupancy mask with set/clear/clear-all commands and one-hot decode
//
// Keeps a registered N-bit occupancy mask that feeds the priority encoder's
// one-hot input. Commands flow through two stages: S1 registers op/idx, and S2
// commits to the mask. A clear-all command starts a sweep that zeroes CHUNK
// bits per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  command accepted this cycle when cmd_valid is also high
//   cmd_op     00 nop, 01 set, 10 clear, 11 clear-all
//   cmd_idx    binary bit index for set/clear
//   mask       registered occupancy mask
//   dec_valid  one-cycle pulse qualifying dec_oht
//   dec_oht    one-hot of the committed index
//   count      number of set bits in mask, 0..N
//   full       count == N
//   empty      count == 0
//   err        one-cycle pulse on a redundant set or clear

module onehot_mask_decoder #(
  parameter int N     = 1024,
  parameter int W     = 10,
  parameter int CHUNK = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_idx,
  output logic [N-1:0] mask,
  output logic         dec_valid,
  output logic [N-1:0] dec_oht,
  output logic [W:0]   count,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int          NCHUNK = N / CHUNK;
  localparam int          KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int          LEVELS = W / 2;
  localparam logic [W:0]  N_CNT  = (W+1)'(N);
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  localparam logic [1:0] OP_NOP     = 2'b00;
  localparam logic [1:0] OP_SET     = 2'b01;
  localparam logic [1:0] OP_CLR     = 2'b10;
  localparam logic [1:0] OP_CLR_ALL = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic           s1_valid_q, s1_valid_d;
  logic [1:0]     s1_op_q, s1_op_d;
  logic [W-1:0]   s1_idx_q, s1_idx_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [W:0]     count_q, count_d;
  logic           full_q, full_d;
  logic           empty_q, empty_d;
  logic           dec_valid_q, dec_valid_d;
  logic [N-1:0]   dec_oht_q, dec_oht_d;
  logic           err_q, err_d;
  logic           cmd_ready_q, cmd_ready_d;

  logic [N-1:0]   idx_oht;
  logic [N-1:0]   sweep_clr;
  logic           hit;

  // Hierarchical decode of the S1 index: each level consumes two index bits
  // (most significant first) and fans every active node out to four children.
  // The last level is exactly 1 << s1_idx_q.
  genvar gl, gj;
  generate
    for (gl = 0; gl < LEVELS; gl++) begin : g_lvl
      localparam int SZ = 4 ** gl;
      logic [SZ-1:0]   prev;
      logic [4*SZ-1:0] exp_v;
      logic [3:0]      sel;

      if (gl == 0) begin : g_root
        assign prev = 1'b1;
      end else begin : g_inner
        assign prev = g_lvl[gl-1].exp_v;
      end

      assign sel = 4'b0001 << s1_idx_q[W-1-2*gl -: 2];

      for (gj = 0; gj < SZ; gj++) begin : g_node
        assign exp_v[4*gj +: 4] = {4{prev[gj]}} & sel;
      end
    end
  endgenerate

  assign idx_oht = g_lvl[LEVELS-1].exp_v;
  assign hit     = |(mask_q & idx_oht);

  // Chunk-select mask for the sweep: all ones over chunk k_q.
  genvar gc;
  generate
    for (gc = 0; gc < NCHUNK; gc++) begin : g_chunk
      assign sweep_clr[gc*CHUNK +: CHUNK] = {CHUNK{k_q == KW'(gc)}};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    mask_d      = mask_q;
    count_d     = count_q;
    dec_valid_d = 1'b0;
    dec_oht_d   = dec_oht_q;
    err_d       = 1'b0;

    s1_valid_d  = cmd_valid && cmd_ready_q;
    s1_op_d     = cmd_op;
    s1_idx_d    = cmd_idx;

    if (state_q == SWEEP) begin
      mask_d = mask_q & ~sweep_clr;
      if (k_q == K_LAST) begin
        count_d = '0;
        state_d = IDLE;
        k_d     = '0;
      end else begin
        k_d = k_q + KW'(1);
      end
    end else if (s1_valid_q) begin
      // S2 sees mask_q as committed on the previous edge, so back-to-back
      // commands to the same index behave as strictly in-order execution.
      case (s1_op_q)
        OP_SET: begin
          dec_valid_d = 1'b1;
          dec_oht_d   = idx_oht;
          if (hit) begin
            err_d = 1'b1;
          end else begin
            mask_d  = mask_q | idx_oht;
            count_d = count_q + (W+1)'(1);
          end
        end
        OP_CLR: begin
          dec_valid_d = 1'b1;
          dec_oht_d   = idx_oht;
          if (!hit) begin
            err_d = 1'b1;
          end else begin
            mask_d  = mask_q & ~idx_oht;
            count_d = count_q - (W+1)'(1);
          end
        end
        OP_CLR_ALL: begin
          state_d = SWEEP;
          k_d     = '0;
        end
        default: begin
        end
      endcase
    end

    full_d  = (count_d == N_CNT);
    empty_d = (count_d == '0);

    // Registered ready: needs IDLE on both sides of the edge, so it drops the
    // cycle a clear-all enters S1 and returns one cycle after the sweep ends.
    cmd_ready_d = (state_d == IDLE) && (state_q == IDLE) &&
                  !(s1_valid_d && (s1_op_d == OP_CLR_ALL));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_NOP;
      s1_idx_q    <= '0;
      mask_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      dec_valid_q <= 1'b0;
      dec_oht_q   <= '0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_idx_q    <= s1_idx_d;
      mask_q      <= mask_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      dec_valid_q <= dec_valid_d;
      dec_oht_q   <= dec_oht_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign mask      = mask_q;
  assign dec_valid = dec_valid_q;
  assign dec_oht   = dec_oht_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign err       = err_q;

endmodule

// File: tb/tb_onehot_mask_decoder.sv
// tb/tb_onehot_mask_decoder.sv - scoreboard bench for onehot_mask_decoder

module tb_onehot_mask_decoder;

    localparam int N      = 1024;
    localparam int W      = 10;
    localparam int CHUNK  = 64;
    localparam int NCHUNK = N / CHUNK;

    typedef struct {
        int           due;
        logic [N-1:0] m;
        int           cnt;
        bit           dv;
        int           idx;
        bit           er;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_idx = '0;
    logic [N-1:0] mask;
    logic         dec_valid;
    logic [N-1:0] dec_oht;
    logic [W:0]   count;
    logic         full;
    logic         empty;
    logic         err;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [N-1:0] model = '0;
    int           model_cnt = 0;
    logic [N-1:0] zero_v = '0;
    exp_t         sb[$];

    onehot_mask_decoder #(.N(N), .W(W), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .mask      (mask),
        .dec_valid (dec_valid),
        .dec_oht   (dec_oht),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_due();
        exp_t         e;
        logic [N-1:0] oh;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            total++;
            if (mask !== e.m) begin
                bad++;
                $error("FAIL mask observed_ones=%0d expected_ones=%0d", $countones(mask), $countones(e.m));
            end
            total++;
            if (count !== (W+1)'(e.cnt)) begin
                bad++;
                $error("FAIL count observed=%0d expected=%0d", count, e.cnt);
            end
            total++;
            if (full !== (e.cnt == N)) begin
                bad++;
                $error("FAIL full observed=%0b", full);
            end
            total++;
            if (empty !== (e.cnt == 0)) begin
                bad++;
                $error("FAIL empty observed=%0b", empty);
            end
            total++;
            if (dec_valid !== e.dv) begin
                bad++;
                $error("FAIL dec_valid observed=%0b expected=%0b", dec_valid, e.dv);
            end
            total++;
            if (err !== e.er) begin
                bad++;
                $error("FAIL err observed=%0b expected=%0b", err, e.er);
            end
            if (e.dv) begin
                oh = '0;
                oh[e.idx] = 1'b1;
                total++;
                if (dec_oht !== oh) begin
                    bad++;
                    $error("FAIL dec_oht idx=%0d observed_ones=%0d", e.idx, $countones(dec_oht));
                end
            end
        end else begin
            total++;
            if (dec_valid !== 1'b0) begin
                bad++;
                $error("FAIL dec_valid_idle observed=%0b", dec_valid);
            end
            total++;
            if (err !== 1'b0) begin
                bad++;
                $error("FAIL err_idle observed=%0b", err);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        check_due();
    endtask

    task automatic model_push(input logic [1:0] op, input int idx, input int due);
        exp_t e;
        e.dv  = 1'b0;
        e.er  = 1'b0;
        e.idx = idx;
        case (op)
            2'b01: begin
                e.dv = 1'b1;
                if (model[idx]) e.er = 1'b1;
                else begin model[idx] = 1'b1; model_cnt++; end
            end
            2'b10: begin
                e.dv = 1'b1;
                if (!model[idx]) e.er = 1'b1;
                else begin model[idx] = 1'b0; model_cnt--; end
            end
            default: begin
            end
        endcase
        e.m   = model;
        e.cnt = model_cnt;
        e.due = due;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input int idx);
        int waited = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = W'(idx);
        while (cmd_ready !== 1'b1 && waited < 50) begin
            cycle();
            waited++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $error("FAIL ready_wait observed=%0b", cmd_ready);
        end
        model_push(op, idx, cyc + 2);
        cycle();
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        total++;
        if (sb.size() !== 0) begin
            bad++;
            $error("FAIL drain pending=%0d", sb.size());
        end
        cycle();
    endtask

    initial begin
        int               t;
        logic [CHUNK-1:0] ch;
        logic [CHUNK-1:0] expc;

        rst = 1'b0;
        repeat (3) cycle();
        total++;
        if (mask !== zero_v) begin
            bad++;
            $error("FAIL reset_mask ones=%0d", $countones(mask));
        end
        total++;
        if (count !== '0) begin
            bad++;
            $error("FAIL reset_count observed=%0d", count);
        end
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $error("FAIL reset_empty observed=%0b", empty);
        end
        total++;
        if (full !== 1'b0) begin
            bad++;
            $error("FAIL reset_full observed=%0b", full);
        end
        total++;
        if (dec_valid !== 1'b0) begin
            bad++;
            $error("FAIL reset_dec_valid observed=%0b", dec_valid);
        end
        total++;
        if (err !== 1'b0) begin
            bad++;
            $error("FAIL reset_err observed=%0b", err);
        end
        rst = 1'b1;
        cycle();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $error("FAIL ready_after_reset observed=%0b", cmd_ready);
        end

        issue(2'b10, 9);
        drain();

        issue(2'b01, 5);
        issue(2'b01, 5);
        drain();
        issue(2'b10, 5);
        drain();

        issue(2'b01, 0);
        issue(2'b01, 1023);
        issue(2'b01, 517);
        issue(2'b00, 0);
        drain();

        for (int i = 0; i < N; i++) issue(2'b01, i);
        drain();
        issue(2'b01, 3);
        drain();

        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_idx   = '0;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $error("FAIL clrall_ready observed=%0b", cmd_ready);
        end
        t = cyc;
        cycle();
        model     = '0;
        model_cnt = 0;
        cmd_op    = 2'b01;
        cmd_idx   = W'(7);
        while (cyc <= t + 18) begin
            total++;
            if (cmd_ready !== 1'b0) begin
                bad++;
                $error("FAIL sweep_ready cyc=%0d observed=%0b", cyc - t, cmd_ready);
            end
            for (int k = 0; k < NCHUNK; k++) begin
                ch   = mask[k*CHUNK +: CHUNK];
                expc = (cyc >= t + 3 + k) ? '0 : '1;
                total++;
                if (ch !== expc) begin
                    bad++;
                    $error("FAIL sweep_chunk cyc=%0d k=%0d observed=%h expected=%h", cyc - t, k, ch, expc);
                end
            end
            total++;
            if (count !== ((cyc == t + 18) ? (W+1)'(0) : (W+1)'(N))) begin
                bad++;
                $error("FAIL sweep_count cyc=%0d observed=%0d", cyc - t, count);
            end
            total++;
            if (empty !== (cyc == t + 18)) begin
                bad++;
                $error("FAIL sweep_empty cyc=%0d observed=%0b", cyc - t, empty);
            end
            cycle();
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $error("FAIL ready_after_sweep observed=%0b", cmd_ready);
        end
        model_push(2'b01, 7, cyc + 2);
        cycle();
        cmd_valid = 1'b0;
        drain();

        issue(2'b01, 100);
        issue(2'b01, 900);
        drain();
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        t = cyc;
        cycle();
        cmd_valid = 1'b0;
        model     = '0;
        model_cnt = 0;
        while (cyc < t + 10) cycle();
        total++;
        if (mask[900] !== 1'b1) begin
            bad++;
            $error("FAIL pre_reset_bit900 observed=%0b", mask[900]);
        end
        total++;
        if (mask[100] !== 1'b0) begin
            bad++;
            $error("FAIL pre_reset_bit100 observed=%0b", mask[100]);
        end
        rst = 1'b0;
        cycle();
        total++;
        if (mask !== zero_v) begin
            bad++;
            $error("FAIL midsweep_reset_mask ones=%0d", $countones(mask));
        end
        total++;
        if (count !== '0) begin
            bad++;
            $error("FAIL midsweep_reset_count observed=%0d", count);
        end
        total++;
        if (empty !== 1'b1) begin
            bad++;
            $error("FAIL midsweep_reset_empty observed=%0b", empty);
        end
        total++;
        if (full !== 1'b0) begin
            bad++;
            $error("FAIL midsweep_reset_full observed=%0b", full);
        end
        rst = 1'b1;
        cycle();
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $error("FAIL ready_after_midsweep_reset observed=%0b", cmd_ready);
        end
        issue(2'b01, 2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
